// File: rtl/sprite_line_engine.sv
// sprite_line_engine
//   Line-buffered sprite engine. Sprite position/attribute registers are
//   loaded from the CPU write bus. During horizontal blank the engine finds
//   the sprites that hit the next scanline and fetches their pixel bytes from
//   a synchronous ROM into the fill bank of a double-buffered line buffer.
//   During active display the display bank is streamed out, one column per
//   cycle, with a single cycle of latency.
//
// Optional feature: define SPR_COLLISION_EN to add the `collision` output.
//
// Ports
//   clk, rst          sole clock, synchronous active-high reset
//   wr_en             CPU write strobe
//   RAM_addr          CPU write address
//   sprite_RAM_din    CPU write data
//   line_start        one-cycle pulse at start of hblank (swaps banks)
//   next_row          row to render into the fill bank, sampled on line_start
//   col               current display column
//   rom_addr          sprite ROM address {num[5:0], row[3:0], byte[1:0]}
//   rom_data          ROM data, valid one cycle after rom_addr
//   pix_valid         non-transparent sprite pixel at the column (registered)
//   pix_data          2-bit colour code, 0 when not valid
//   pix_pal           palette index of the owning sprite, 0 when not valid
//   busy              fill in progress (not IDLE/DONE)
//   late              one-cycle pulse when line_start arrives while busy
//   overflow          too many sprites hit the line now displayed
//   collision         (SPR_COLLISION_EN) opaque pixels overlapped on that line
`default_nettype none

module sprite_line_engine #(
    parameter int          NUM_SPRITES  = 8,
    parameter int          MAX_PER_LINE = 8,
    parameter int          LINE_W       = 224,
    parameter logic [15:0] POS_BASE     = 16'h5060,
    parameter logic [15:0] ATTR_BASE    = 16'h4FF0,
    parameter logic [15:0] FLIP_ADDR    = 16'h5003
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [15:0] RAM_addr,
    input  logic [7:0]  sprite_RAM_din,
    input  logic        line_start,
    input  logic [8:0]  next_row,
    input  logic [9:0]  col,
    output logic [11:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic        pix_valid,
    output logic [1:0]  pix_data,
    output logic [7:0]  pix_pal,
    output logic        busy,
    output logic        late,
    output logic        overflow
`ifdef SPR_COLLISION_EN
    ,
    output logic        collision
`endif
);

    localparam int CW  = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam int SW  = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int HW  = $clog2(MAX_PER_LINE + 1);
    localparam int HIW = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_EVAL, S_FETCH, S_WAIT, S_WRITE, S_DONE
    } state_t;

    // CPU-visible sprite registers
    logic [7:0] r_x   [NUM_SPRITES];
    logic [7:0] r_y   [NUM_SPRITES];
    logic [7:0] r_nf  [NUM_SPRITES];
    logic [7:0] r_pal [NUM_SPRITES];
    logic [7:0] r_flip;

    // Fill control
    state_t          r_state;
    logic            r_bank;
    logic [CW-1:0]   r_cnt;
    logic [SW-1:0]   r_idx;
    logic [HW-1:0]   r_hcnt;
    logic [HIW-1:0]  r_hsel;
    logic [1:0]      r_b;
    logic [1:0]      r_k;
    logic [7:0]      r_row;
    logic [7:0]      r_byte;
    logic [11:0]     r_rom_addr;
    logic            r_late;
    logic            r_overflow;
    logic            r_ovf_fill;
`ifdef SPR_COLLISION_EN
    logic            r_collision;
    logic            r_coll_fill;
`endif

    // Hit list snapshotted during EVAL
    logic [5:0] r_h_num  [MAX_PER_LINE];
    logic       r_h_xf   [MAX_PER_LINE];
    logic [3:0] r_h_reff [MAX_PER_LINE];
    logic [7:0] r_h_scol [MAX_PER_LINE];
    logic [7:0] r_h_pal  [MAX_PER_LINE];

    // Line banks
    logic       r_vld  [2][LINE_W];
    logic [1:0] r_dat  [2][LINE_W];
    logic [7:0] r_lpal [2][LINE_W];

    // Display pipeline
    logic       r_pix_v_p1;
    logic [1:0] r_pix_d_p1;
    logic [7:0] r_pix_p_p1;

    logic        w_busy;
    logic        w_fill;
    logic [7:0]  w_srow;
    logic [7:0]  w_r;
    logic        w_hit;
    logic        w_xf;
    logic        w_yf;
    logic [3:0]  w_reff;
    logic [7:0]  w_scol;
    logic        w_store;
    logic [3:0]  w_c;
    logic [3:0]  w_cc;
    logic [8:0]  w_t;
    logic [7:0]  w_byte;
    logic [1:0]  w_p;
    logic        w_inrange;
    logic [CW-1:0] w_tidx;
    logic        w_old;
    logic        w_wr;
    logic        w_coll;
    logic        w_col_in;
    logic [CW-1:0] w_cidx;
    logic        w_unused;

    assign w_unused = next_row[8];

    assign w_busy = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_fill = ~r_bank;

    // Hit test for the sprite under evaluation (8-bit modular screen mapping)
    assign w_srow  = 8'd15 - r_y[r_idx];
    assign w_r     = r_row - w_srow;
    assign w_hit   = (w_r < 8'd16);
    assign w_xf    = r_nf[r_idx][1] ^ (|r_flip);
    assign w_yf    = r_nf[r_idx][0] ^ (|r_flip);
    assign w_reff  = w_yf ? (4'd15 - w_r[3:0]) : w_r[3:0];
    assign w_scol  = 8'd240 - r_x[r_idx];
    assign w_store = (r_state == S_EVAL) && !line_start && w_hit &&
                     (r_hcnt != HW'(MAX_PER_LINE));

    // Pixel placement; the ROM byte is live on the first WRITE cycle and held
    // in r_byte for the remaining three.
    assign w_c       = {r_b, r_k};
    assign w_cc      = r_h_xf[r_hsel] ? (4'd15 - w_c) : w_c;
    assign w_t       = {1'b0, r_h_scol[r_hsel]} + {5'd0, w_cc};
    assign w_byte    = (r_k == 2'd0) ? rom_data : r_byte;
    assign w_p       = w_byte[{r_k, 1'b0} +: 2];
    assign w_inrange = ({1'b0, w_t} < 10'(LINE_W));
    assign w_tidx    = w_t[CW-1:0];
    assign w_old     = r_vld[w_fill][w_tidx];
    assign w_wr      = (r_state == S_WRITE) && !line_start && (w_p != 2'd0) &&
                       w_inrange && !w_old;
    assign w_coll    = (r_state == S_WRITE) && !line_start && (w_p != 2'd0) &&
                       w_inrange && w_old;

    assign w_col_in = (col < 10'(LINE_W));
    assign w_cidx   = col[CW-1:0];

    // CPU register writes
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_x[i]   <= 8'd0;
                r_y[i]   <= 8'd0;
                r_nf[i]  <= 8'd0;
                r_pal[i] <= 8'd0;
            end
            r_flip <= 8'd0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                if (RAM_addr == POS_BASE + 16'(2 * i))
                    r_x[i] <= sprite_RAM_din;
                if (RAM_addr == POS_BASE + 16'(2 * i + 1))
                    r_y[i] <= sprite_RAM_din;
                if (RAM_addr == ATTR_BASE + 16'(2 * i))
                    r_nf[i] <= sprite_RAM_din;
                if (RAM_addr == ATTR_BASE + 16'(2 * i + 1))
                    r_pal[i] <= sprite_RAM_din;
            end
            if (RAM_addr == FLIP_ADDR)
                r_flip <= sprite_RAM_din;
        end
    end

    // Fill FSM; line_start overrides every state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_bank     <= 1'b0;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_hcnt     <= '0;
            r_hsel     <= '0;
            r_b        <= 2'd0;
            r_k        <= 2'd0;
            r_row      <= 8'd0;
            r_rom_addr <= 12'd0;
            r_late     <= 1'b0;
            r_overflow <= 1'b0;
            r_ovf_fill <= 1'b0;
`ifdef SPR_COLLISION_EN
            r_collision <= 1'b0;
            r_coll_fill <= 1'b0;
`endif
            for (int bk = 0; bk < 2; bk++)
                for (int i = 0; i < LINE_W; i++)
                    r_vld[bk][i] <= 1'b0;
        end else begin
            r_late <= 1'b0;
            if (line_start) begin
                r_late     <= w_busy;
                r_bank     <= ~r_bank;
                r_row      <= next_row[7:0];
                r_overflow <= r_ovf_fill;
                r_ovf_fill <= 1'b0;
`ifdef SPR_COLLISION_EN
                r_collision <= r_coll_fill;
                r_coll_fill <= 1'b0;
`endif
                r_cnt      <= '0;
                r_state    <= S_CLEAR;
            end else begin
                case (r_state)
                    S_CLEAR: begin
                        r_vld[w_fill][r_cnt] <= 1'b0;
                        if (r_cnt == CW'(LINE_W - 1)) begin
                            r_state <= S_EVAL;
                            r_idx   <= '0;
                            r_hcnt  <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_EVAL: begin
                        if (w_hit) begin
                            if (r_hcnt == HW'(MAX_PER_LINE))
                                r_ovf_fill <= 1'b1;
                            else
                                r_hcnt <= r_hcnt + 1'b1;
                        end
                        if (r_idx == SW'(NUM_SPRITES - 1)) begin
                            r_hsel <= '0;
                            r_b    <= 2'd0;
                            r_state <= ((r_hcnt != '0) || w_hit) ? S_FETCH : S_DONE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                    S_FETCH: begin
                        r_rom_addr <= {r_h_num[r_hsel], r_h_reff[r_hsel], r_b};
                        r_state    <= S_WAIT;
                    end
                    S_WAIT: begin
                        r_k     <= 2'd0;
                        r_state <= S_WRITE;
                    end
                    S_WRITE: begin
                        if (r_k == 2'd0)
                            r_byte <= rom_data;
                        if (w_wr)
                            r_vld[w_fill][w_tidx] <= 1'b1;
`ifdef SPR_COLLISION_EN
                        if (w_coll)
                            r_coll_fill <= 1'b1;
`endif
                        if (r_k == 2'd3) begin
                            if (r_b == 2'd3) begin
                                r_b <= 2'd0;
                                if (HW'(r_hsel) + HW'(1) == r_hcnt) begin
                                    r_state <= S_DONE;
                                end else begin
                                    r_hsel  <= r_hsel + 1'b1;
                                    r_state <= S_FETCH;
                                end
                            end else begin
                                r_b     <= r_b + 2'd1;
                                r_state <= S_FETCH;
                            end
                        end else begin
                            r_k <= r_k + 2'd1;
                        end
                    end
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    // Hit-list snapshot and line-bank payload (no reset: qualified by valid)
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_h_num[r_hcnt[HIW-1:0]]  <= r_nf[r_idx][7:2];
            r_h_xf[r_hcnt[HIW-1:0]]   <= w_xf;
            r_h_reff[r_hcnt[HIW-1:0]] <= w_reff;
            r_h_scol[r_hcnt[HIW-1:0]] <= w_scol;
            r_h_pal[r_hcnt[HIW-1:0]]  <= r_pal[r_idx];
        end
        if (w_wr) begin
            r_dat[w_fill][w_tidx]  <= w_p;
            r_lpal[w_fill][w_tidx] <= r_h_pal[r_hsel];
        end
    end

    // Display read: col -> pix_* one cycle later
    always_ff @(posedge clk) begin
        if (rst || !w_col_in) begin
            r_pix_v_p1 <= 1'b0;
            r_pix_d_p1 <= 2'd0;
            r_pix_p_p1 <= 8'd0;
        end else begin
            r_pix_v_p1 <= r_vld[r_bank][w_cidx];
            r_pix_d_p1 <= r_vld[r_bank][w_cidx] ? r_dat[r_bank][w_cidx] : 2'd0;
            r_pix_p_p1 <= r_vld[r_bank][w_cidx] ? r_lpal[r_bank][w_cidx] : 8'd0;
        end
    end

    assign rom_addr  = r_rom_addr;
    assign pix_valid = r_pix_v_p1;
    assign pix_data  = r_pix_d_p1;
    assign pix_pal   = r_pix_p_p1;
    assign busy      = w_busy;
    assign late      = r_late;
    assign overflow  = r_overflow;
`ifdef SPR_COLLISION_EN
    assign collision = r_collision;
`endif

endmodule

`default_nettype wire
